// File: rtl/master_write_control.sv
// master_write_control: skewed per-lane write-address/enable generator for draining a systolic result tile.
// Lane j trails lane 0 by j cycles; each enabled lane writes rows base..base+row_r.
module master_write_control #(
    parameter int addr_width = 8,
    parameter int width_height = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                active,
    input  logic [addr_width-1:0]               base_addr,
    input  logic [$clog2(width_height)-1:0]     num_row,
    input  logic [$clog2(width_height)-1:0]     num_col,
    input  logic                                in_valid,
    output logic [addr_width*width_height-1:0]  out_addr,
    output logic [width_height-1:0]             out_we,
    output logic                                done
);
    localparam int out_addr_width = addr_width * width_height;
    localparam int cw = $clog2(width_height);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

    state_t              state, next;
    logic [cw:0]         count;
    logic [addr_width-1:0] base_r;
    logic [cw-1:0]       row_r, col_r;
    logic                last;

    assign last = state == WRITE && count == {1'b0, row_r} + {1'b0, col_r};

    always_comb begin
        next = state;
        next = state == IDLE ? (active ? WAIT : IDLE) :
               state == WAIT ? (in_valid ? WRITE : WAIT) :
               (last ? IDLE : WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            done   <= 1'b0;
            base_r <= '0;
            row_r  <= '0;
            col_r  <= '0;
        end else begin
            state <= next;
            done  <= last;
            count <= state == WRITE && !last ? count + 1'b1 : '0;
            if (state == IDLE && active) begin
                base_r <= base_addr;
                row_r  <= num_row;
                col_r  <= num_col;
            end
        end
    end

    // Lane j is on row count-j, valid while that row lies inside the tile.
    for (genvar j = 0; j < width_height; j++) begin : g_lane
        localparam logic [cw:0] jj = (cw + 1)'(j);
        logic [cw:0] diff;
        assign diff = count - jj;
        assign out_we[j] = state == WRITE && jj <= {1'b0, col_r} && count >= jj && diff <= {1'b0, row_r};
        assign out_addr[j*addr_width +: addr_width] = out_we[j] ? base_r + addr_width'(diff) : '0;
    end

    logic unused;
    assign unused = ^out_addr_width;
endmodule

// File: tb/tb_master_write_control.sv
// tb_master_write_control: directed checks of skewed write sequencing, wrap, full tile, ignore rules and reset abort.
module tb_master_write_control;
    logic         clk = 0;
    logic         reset, active, in_valid;
    logic [7:0]   base_addr;
    logic [3:0]   num_row, num_col;
    logic [127:0] out_addr;
    logic [15:0]  out_we;
    logic         done;
    int checks = 0;
    int errors = 0;

    master_write_control dut (
        .clk(clk), .reset(reset), .active(active), .base_addr(base_addr),
        .num_row(num_row), .num_col(num_col), .in_valid(in_valid),
        .out_addr(out_addr), .out_we(out_we), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] b, input logic [3:0] r, input logic [3:0] c);
        active = 1; base_addr = b; num_row = r; num_col = c;
        step();
        active = 0;
    endtask

    initial begin
        int writes, pulses;
        logic [15:0] seen;
        logic addr_ok, first_ok;
        reset = 1; active = 0; in_valid = 0; base_addr = 0; num_row = 0; num_col = 0;
        step(); step();
        chk("rst_we", out_we, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_done", done, 0);
        reset = 0;

        // basic skew
        start(8'h10, 2, 1);
        chk("skew_wait_we", out_we, 0);
        in_valid = 1; step(); in_valid = 0;
        chk("skew_c0_we", out_we, 16'h0001);
        chk("skew_c0_addr", out_addr, 128'h10);
        step();
        chk("skew_c1_we", out_we, 16'h0003);
        chk("skew_c1_addr", out_addr, 128'h1011);
        step();
        chk("skew_c2_we", out_we, 16'h0003);
        chk("skew_c2_addr", out_addr, 128'h1112);
        step();
        chk("skew_c3_we", out_we, 16'h0002);
        chk("skew_c3_addr", out_addr, 128'h1200);
        chk("skew_c3_done", done, 0);
        step();
        chk("skew_done", done, 1);
        chk("skew_done_we", out_we, 0);
        step();
        chk("skew_done_low", done, 0);

        // address wrap
        start(8'hFE, 3, 0);
        in_valid = 1; step(); in_valid = 0;
        chk("wrap_c0_we", out_we, 16'h0001);
        chk("wrap_c0_addr", out_addr, 128'hFE);
        step();
        chk("wrap_c1_addr", out_addr, 128'hFF);
        step();
        chk("wrap_c2_we", out_we, 16'h0001);
        chk("wrap_c2_addr", out_addr, 128'h00);
        step();
        chk("wrap_c3_addr", out_addr, 128'h01);
        step();
        chk("wrap_done", done, 1);
        step();

        // full tile
        start(8'h40, 15, 15);
        in_valid = 1; step(); in_valid = 0;
        writes = 0; pulses = 0; seen = 0; addr_ok = 1; first_ok = 1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (out_we != 0) writes++;
            pulses += $countones(out_we);
            for (int j = 0; j < 16; j++) if (out_we[j]) begin
                if (!seen[j]) begin
                    seen[j] = 1;
                    if (k != j) first_ok = 0;
                end
                if (out_addr[j*8 +: 8] !== 8'(8'h40 + k - j)) addr_ok = 0;
            end
            step();
        end
        chk("full_done", done, 1);
        chk("full_writes", writes, 31);
        chk("full_pulses", pulses, 256);
        chk("full_lanes", seen, 16'hFFFF);
        chk("full_first", first_ok, 1);
        chk("full_addr", addr_ok, 1);
        step();

        // ignore rules: in_valid in IDLE, active+in_valid together, active during WRITE
        in_valid = 1; step();
        chk("ign_idle_valid", out_we, 0);
        active = 1; base_addr = 8'h20; num_row = 2; num_col = 1;
        step();
        active = 0; in_valid = 0;
        chk("ign_wait_we", out_we, 0);
        step();
        chk("ign_still_wait", out_we, 0);
        in_valid = 1; step();
        active = 1; base_addr = 8'h99; num_row = 0; num_col = 0; in_valid = 0;
        chk("ign_c0_addr", out_addr, 128'h20);
        step(); in_valid = 1;
        chk("ign_c1_addr", out_addr, 128'h2021);
        step(); in_valid = 0;
        chk("ign_c2_addr", out_addr, 128'h2122);
        step(); active = 0; in_valid = 1;
        chk("ign_c3_addr", out_addr, 128'h2200);
        step();
        chk("ign_done", done, 1);
        step();
        chk("ign_done_once", done, 0);
        chk("ign_no_restart", out_we, 0);
        step(); in_valid = 0;
        chk("ign_no_restart2", out_we, 0);

        // reset abort mid-WRITE
        start(8'h10, 2, 1);
        in_valid = 1; step(); in_valid = 0;
        step(); step();
        chk("abort_c2_addr", out_addr, 128'h1112);
        reset = 1; step(); reset = 0;
        chk("abort_we", out_we, 0);
        chk("abort_addr", out_addr, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", done, 0);
            chk("abort_no_we", out_we, 0);
        end

        // minimum tile then back-to-back start in done cycle
        start(8'h30, 0, 0);
        in_valid = 1; step(); in_valid = 0;
        chk("min_we", out_we, 16'h0001);
        chk("min_addr", out_addr, 128'h30);
        step();
        chk("min_done", done, 1);
        active = 1; base_addr = 8'h50; num_row = 0; num_col = 1;
        step(); active = 0;
        chk("b2b_wait", out_we, 0);
        in_valid = 1; step(); in_valid = 0;
        chk("b2b_c0_we", out_we, 16'h0001);
        chk("b2b_c0_addr", out_addr, 128'h50);
        step();
        chk("b2b_c1_we", out_we, 16'h0002);
        chk("b2b_c1_addr", out_addr, 128'h5000);
        step();
        chk("b2b_done", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/master_write_control.md
MASTER_WRITE_CONTROL -- requirements
Module: master_write_control

Interface
REQ-001 Parameter addr_width, default 8: width of one lane's memory address.
REQ-002 Parameter width_height, default 16: number of array columns and memory lanes.
REQ-003 Local constant out_addr_width SHALL equal addr_width*width_height; cw SHALL equal $clog2(width_height).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 active  input  1  start pulse; accepted only in IDLE.
REQ-007 base_addr  input  addr_width  first row address of the result tile.
REQ-008 num_row  input  cw  last row index, inclusive; rows = num_row+1.
REQ-009 num_col  input  cw  last lane index, inclusive; lanes 0..num_col are written.
REQ-010 in_valid  input  1  array signals that row 0 of lane 0 is available.
REQ-011 out_addr  output  out_addr_width  per-lane write address; lane j occupies bits [j*addr_width +: addr_width].
REQ-012 out_we  output  width_height  per-lane write enable.
REQ-013 done  output  1  registered one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, WRITE.
REQ-015 IDLE: when active=1, the block SHALL latch base_addr, num_row and num_col into registers (base_r, row_r, col_r) and go to WAIT next cycle.
REQ-016 WAIT: when in_valid=1, the block SHALL go to WRITE next cycle with count=0; otherwise it SHALL stay in WAIT.
REQ-017 The count register SHALL be cw+1 bits wide; it SHALL increment once per WRITE cycle.
REQ-018 The last WRITE cycle SHALL be count = row_r + col_r, computed at cw+1 bits; total WRITE cycles = row_r+col_r+1.
REQ-019 After the last WRITE cycle, the FSM SHALL go to IDLE and reset count to 0.
REQ-020 done SHALL be 1 for exactly the one cycle after the last WRITE cycle, and 0 otherwise.
REQ-021 out_we[j] SHALL be 1 only when all of these hold: state=WRITE, j<=col_r, count>=j, and count-j<=row_r.
REQ-022 When out_we[j]=1, lane j out_addr SHALL equal base_r+(count-j), truncated to addr_width (wraps modulo 2^addr_width).
REQ-023 When out_we[j]=0, lane j out_addr SHALL be 0.
REQ-024 out_we and out_addr SHALL be combinational functions of the registered state, count, base_r, row_r and col_r only; there is no input-to-output combinational path.
REQ-025 Lanes j>col_r SHALL never assert out_we.
REQ-026 active SHALL be ignored in WAIT and WRITE; latched parameters SHALL not change until the next IDLE acceptance.
REQ-027 in_valid SHALL be ignored in IDLE and WRITE; a transfer, once in WRITE, SHALL run to completion without stall.
REQ-028 When num_row=0 and num_col=0, the block SHALL perform exactly one WRITE cycle: lane 0 only, address base_r.
REQ-029 When active and in_valid are both 1 in IDLE, in_valid SHALL be ignored; WAIT is still entered.
REQ-030 done and a new active in the same cycle SHALL be legal: the FSM is in IDLE, so active is accepted.

Reset
REQ-031 reset=1 SHALL force state=IDLE, count=0, done=0, base_r=0, row_r=0 and col_r=0 at the next edge, in any state.
REQ-032 reset SHALL take priority over active and in_valid in the same cycle.
REQ-033 During and after reset, out_we SHALL be all 0 and out_addr all 0.
REQ-034 Reset mid-WRITE SHALL abort the transfer: no further out_we and no done pulse.

Verification
REQ-035 Basic skew: base=0x10, num_row=2, num_col=1, in_valid one cycle after WAIT entry -> WRITE begins the cycle after in_valid. Per count: c0 lane0=0x10; c1 lane0=0x11, lane1=0x10; c2 lane0=0x12, lane1=0x11; c3 lane1=0x12. done is high in the next cycle only.
REQ-036 Wrap: base=0xFE, num_row=3, num_col=0 -> lane0 addresses 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles; no other lane enabled.
REQ-037 Full tile: num_row=15, num_col=15 -> 31 WRITE cycles; each lane j writes 16 times, first at count=j; total out_we pulses = 256.
REQ-038 Ignore rules: active pulsed during WRITE, and in_valid toggled in IDLE and WRITE -> transfer unchanged; no restart; done pulses once.
REQ-039 Reset abort: reset asserted at count=2 of REQ-035 -> out_we=0 from the next cycle; done never asserts; a new active then runs a clean transfer.
REQ-040 Minimum tile and back-to-back: num_row=0, num_col=0 -> a single out_we[0] at base. active in the done cycle -> the second transfer enters WAIT with no lost cycle.
